// File: rtl/luhnmod16_gen.sv
// Luhn mod-16 check-nibble generator.
// Forwards a payload of 4-bit nibbles unchanged and appends one check nibble
// that makes the whole frame (payload + check) validate under Luhn mod 16.
module luhnmod16_gen #(
   parameter int SIZE_W = 8
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [SIZE_W-1:0] size,
   input  logic              size_valid,
   output logic              size_ready,
   input  logic [3:0]        data,
   input  logic              data_valid,
   output logic              data_ready,
   output logic [3:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PASS,
      S_CHECK,
      S_DRAIN
   } state_t;

   state_t            r_state;
   logic              r_size_ready;
   logic              r_out_valid;
   logic              r_out_last;
   logic [3:0]        r_out_data;
   logic [3:0]        r_sum;
   logic [SIZE_W-1:0] r_count;
   logic              r_dbl;

   logic              w_out_free;
   logic              w_data_fire;

   // Weight one nibble: doubled nibbles fold to their base-16 digit sum.
   function automatic logic [3:0] weigh(input logic [3:0] v, input logic dbl);
      logic [4:0] t;
      t = {v, 1'b0};
      if (t >= 5'd16) begin
         t = t - 5'd15;
      end
      return dbl ? t[3:0] : v;
   endfunction

   // Check nibble is the additive inverse of the running sum, mod 16.
   function automatic logic [3:0] check_of(input logic [3:0] s);
      return 4'd0 - s;
   endfunction

   // Output register may be (re)loaded when empty or being drained this cycle.
   always_comb begin
      w_out_free  = !r_out_valid || out_ready;
      data_ready  = (r_state == S_PASS) && w_out_free;
      w_data_fire = data_ready && data_valid;
   end

   // Frame sequencer with registered output stage.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_size_ready <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_data   <= 4'd0;
         r_sum        <= 4'd0;
         r_count      <= '0;
         r_dbl        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_size_ready) begin
                  r_size_ready <= 1'b1;
               end else if (size_valid) begin
                  r_count      <= size;
                  r_sum        <= 4'd0;
                  r_dbl        <= size[0];
                  r_size_ready <= 1'b0;
                  r_state      <= (size != '0) ? S_PASS : S_CHECK;
               end
            end
            S_PASS: begin
               if (w_data_fire) begin
                  r_out_data  <= data;
                  r_out_valid <= 1'b1;
                  r_count     <= r_count - SIZE_W'(1);
                  r_dbl       <= ~r_dbl;
                  r_sum       <= r_sum + weigh(data, r_dbl);
                  if (r_count == SIZE_W'(1)) begin
                     r_state <= S_CHECK;
                  end
               end else if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_CHECK: begin
               if (w_out_free) begin
                  r_out_data  <= check_of(r_sum);
                  r_out_valid <= 1'b1;
                  r_out_last  <= 1'b1;
                  r_state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  r_out_valid  <= 1'b0;
                  r_out_last   <= 1'b0;
                  r_size_ready <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign size_ready = r_size_ready;
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign out_data   = r_out_data;

endmodule

// File: tb/tb_luhnmod16_gen.sv
// Bench for luhnmod16_gen: directed frames plus random loopback frames,
// checked against a Luhn mod-16 frame validator computed from the rules.
module tb_luhnmod16_gen;

   localparam int SIZE_W = 8;

   logic              clock = 1'b0;
   logic              rst   = 1'b1;
   logic [SIZE_W-1:0] size = '0;
   logic              size_valid = 1'b0;
   logic              size_ready;
   logic [3:0]        data = 4'd0;
   logic              data_valid = 1'b0;
   logic              data_ready;
   logic [3:0]        out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   int   errors = 0;
   int   checks = 0;
   bit   rnd_ready = 1'b0;
   bit   gaps = 1'b0;
   logic [4:0] obs_q[$];

   luhnmod16_gen #(.SIZE_W(SIZE_W)) dut (
      .clock      (clock),
      .rst        (rst),
      .size       (size),
      .size_valid (size_valid),
      .size_ready (size_ready),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame validator: from the right, odd positions are doubled and
   // replaced by their base-16 digit sum; frame is valid if total % 16 == 0.
   function automatic bit luhn_ok(input logic [3:0] fr[$]);
      int s;
      int v;
      s = 0;
      for (int k = 0; k < fr.size(); k++) begin
         v = int'(fr[fr.size() - 1 - k]);
         if (k % 2 == 1) begin
            v = 2 * v;
            v = v / 16 + v % 16;
         end
         s += v;
      end
      return (s % 16) == 0;
   endfunction

   // Expected check nibble: the unique digit that makes the frame valid.
   function automatic logic [3:0] ref_check(input logic [3:0] p[$]);
      logic [3:0] fr[$];
      for (int c = 0; c < 16; c++) begin
         fr = p;
         fr.push_back(4'(c));
         if (luhn_ok(fr)) return 4'(c);
      end
      return 4'd0;
   endfunction

   // Downstream ready: steady or random, changed just after each edge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: records beats and checks back-pressure on data_ready.
   initial begin
      forever begin
         @(negedge clock);
         if (!rst) begin
            if (out_valid && !out_ready) chk("stall_data_ready", data_ready, 0);
            if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
         end
      end
   end

   task automatic send_size(input int n);
      bit fired;
      int b;
      fired = 1'b0;
      b = 0;
      size = SIZE_W'(n);
      size_valid = 1'b1;
      while (!fired && b < 1000) begin
         @(negedge clock);
         fired = size_ready;
         @(posedge clock);
         #1;
         b++;
      end
      size_valid = 1'b0;
      chk("size_accept", fired, 1);
   endtask

   task automatic send_data(input logic [3:0] p[$], input int n);
      bit fired;
      bit ok;
      int b;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         fired = 1'b0;
         b = 0;
         data = p[i];
         while (!fired && b < 1000) begin
            data_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clock);
            fired = data_valid && data_ready;
            @(posedge clock);
            #1;
            b++;
         end
         if (!fired) ok = 1'b0;
      end
      data_valid = 1'b0;
      chk("data_accept", ok, 1);
   endtask

   task automatic run_frame(input string tag, input logic [3:0] p[$], input int exp_chk);
      int b;
      int bad;
      int k;
      logic [3:0] fr[$];
      logic [4:0] lastb;
      obs_q.delete();
      send_size(p.size());
      send_data(p, p.size());
      b = 0;
      while (!(obs_q.size() > 0 && obs_q[obs_q.size() - 1][4]) && b < 5000) begin
         @(posedge clock);
         #1;
         b++;
      end
      @(posedge clock);
      #1;
      chk({tag, "_beats"}, obs_q.size(), p.size() + 1);
      bad = 0;
      for (int i = 0; i < p.size() && i < obs_q.size(); i++) begin
         if (obs_q[i][3:0] !== p[i] || obs_q[i][4] !== 1'b0) bad++;
      end
      chk({tag, "_payload"}, bad, 0);
      lastb = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 5'h00;
      chk({tag, "_last"}, lastb[4], 1);
      chk({tag, "_check"}, lastb[3:0], ref_check(p));
      if (exp_chk >= 0) chk({tag, "_spec"}, lastb[3:0], exp_chk);
      fr.delete();
      foreach (obs_q[i]) fr.push_back(obs_q[i][3:0]);
      chk({tag, "_loop"}, luhn_ok(fr), 1);
      if (fr.size() > 1) begin
         k = $urandom_range(0, fr.size() - 2);
         fr[k] = fr[k] ^ 4'($urandom_range(1, 15));
         chk({tag, "_flip"}, luhn_ok(fr), 0);
      end
   endtask

   initial begin
      logic [3:0] p[$];
      int n;
      int lasts;

      // Reset state
      #12;
      chk("rst_size_ready", size_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_data_ready", data_ready, 0);
      @(posedge clock);
      #2;
      rst = 1'b0;
      #1;
      chk("rel_size_ready_low", size_ready, 0);
      @(posedge clock);
      #1;
      chk("rel_size_ready_high", size_ready, 1);

      // Directed frames
      p = '{4'hA, 4'h3, 4'hD, 4'hC, 4'h1, 4'h5, 4'h9};
      run_frame("f7", p, 7);

      gaps = 1'b1;
      p = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF, 4'hC, 4'hC, 4'h9};
      run_frame("f11_gaps", p, 12);
      gaps = 1'b0;

      rnd_ready = 1'b1;
      p = '{4'h4, 4'hC, 4'hA, 4'h5};
      run_frame("f4_rdy", p, 15);
      rnd_ready = 1'b0;

      p = '{4'h6, 4'h9, 4'h4, 4'h3, 4'h2, 4'h1, 4'hA};
      run_frame("f7b", p, 6);

      p.delete();
      run_frame("f0", p, 0);

      // Reset in the middle of a frame
      obs_q.delete();
      p.delete();
      for (int i = 0; i < 10; i++) p.push_back(4'($urandom_range(0, 15)));
      send_size(10);
      send_data(p, 3);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_size_ready", size_ready, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_data_ready", data_ready, 0);
      @(posedge clock);
      @(posedge clock);
      #3;
      rst = 1'b0;
      #1;
      chk("mid_rel_size_ready_low", size_ready, 0);
      @(posedge clock);
      #1;
      chk("mid_rel_size_ready_high", size_ready, 1);
      lasts = 0;
      foreach (obs_q[i]) if (obs_q[i][4]) lasts++;
      chk("mid_no_last", lasts, 0);
      p = '{4'h4, 4'hC, 4'hA, 4'h5};
      run_frame("after_rst", p, 15);

      // Random loopback frames
      for (int f = 0; f < 50; f++) begin
         n = $urandom_range(1, 255);
         p.delete();
         for (int i = 0; i < n; i++) p.push_back(4'($urandom_range(0, 15)));
         rnd_ready = (f % 3 == 1);
         gaps = (f % 4 == 2);
         run_frame("rand", p, -1);
      end
      rnd_ready = 1'b0;
      gaps = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
